// File: rtl/scan_pkg.sv
// Shared types and elaboration checks for the RAM scan reader.
// Defines the sequencer state encoding and the legal parameter range.
package scan_pkg;

   localparam int unsigned SCAN_ADDR_W = 5;
   localparam int unsigned SCAN_DATA_W = 3;

   typedef enum logic {
      SETTLE = 1'b0,
      SHOW   = 1'b1
   } scan_state_e;

   // A step must never land inside a settle window, so the step period has to
   // outlast the read latency plus the capture edge.
   function automatic bit scan_params_ok(input int unsigned tick_cycles,
                                         input int unsigned rd_latency);
      return (rd_latency >= 1) && (rd_latency <= 3) &&
             (tick_cycles >= rd_latency + 2);
   endfunction

endpackage

// File: rtl/ram_scan_reader_tick_gen.sv
// Enable-gated prescaler: tick is high for the cycle in which the count sits
// on its last value with enable set; the count freezes while enable is low.
module tick_gen #(
   parameter int unsigned TICK_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (enable) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ram_scan_reader.sv
// Read-side sequencer: walks the RAM read address at the tick rate, waits out
// the RAM read latency, then presents an aligned {address, data} pair.
module ram_scan_reader
   import scan_pkg::*;
#(
   parameter int unsigned ADDR_W      = SCAN_ADDR_W,
   parameter int unsigned DATA_W      = SCAN_DATA_W,
   parameter int unsigned TICK_CYCLES = 50_000_000,
   parameter int unsigned RD_LATENCY  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid
);

   generate
      if (!scan_params_ok(TICK_CYCLES, RD_LATENCY)) begin : g_bad_params
         $error("ram_scan_reader: need 1 <= RD_LATENCY <= 3 and TICK_CYCLES >= RD_LATENCY+2");
      end
   endgenerate

   localparam logic [1:0] SETTLE_INIT = 2'(RD_LATENCY);

   logic              tick;
   scan_state_e       state_q,      state_d;
   logic [1:0]        settle_q,     settle_d;
   logic [ADDR_W-1:0] rd_addr_q,    rd_addr_d;
   logic [ADDR_W-1:0] disp_addr_q,  disp_addr_d;
   logic [DATA_W-1:0] disp_data_q,  disp_data_d;
   logic              disp_valid_q, disp_valid_d;

   tick_gen #(
      .TICK_CYCLES(TICK_CYCLES)
   ) u_tick_gen (
      .clk   (clk),
      .rst   (reset),
      .enable(enable),
      .tick  (tick)
   );

   always_comb begin
      state_d      = state_q;
      settle_d     = settle_q;
      rd_addr_d    = rd_addr_q;
      disp_addr_d  = disp_addr_q;
      disp_data_d  = disp_data_q;
      disp_valid_d = 1'b0;

      case (state_q)
         SETTLE: begin
            if (settle_q == 2'd0) begin
               disp_addr_d  = rd_addr_q;
               disp_data_d  = rd_data;
               disp_valid_d = 1'b1;
               state_d      = SHOW;
            end else begin
               settle_d = settle_q - 2'd1;
            end
         end
         SHOW: begin
            // Keep resampling so writes to the shown location reach the display.
            disp_data_d = rd_data;
         end
         default: begin
            state_d = SETTLE;
         end
      endcase

      // A tick only arrives in SHOW; the parameter check keeps it out of SETTLE.
      if (tick) begin
         rd_addr_d = rd_addr_q + ADDR_W'(1);
         state_d   = SETTLE;
         settle_d  = SETTLE_INIT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= SETTLE;
         settle_q     <= SETTLE_INIT;
         rd_addr_q    <= '0;
         disp_addr_q  <= '0;
         disp_data_q  <= '0;
         disp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_q     <= settle_d;
         rd_addr_q    <= rd_addr_d;
         disp_addr_q  <= disp_addr_d;
         disp_data_q  <= disp_data_d;
         disp_valid_q <= disp_valid_d;
      end
   end

   assign rd_addr    = rd_addr_q;
   assign disp_addr  = disp_addr_q;
   assign disp_data  = disp_data_q;
   assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader: one instance with RD_LATENCY=1 and one
// with RD_LATENCY=3, each fed by a registered-read RAM model.
module tb_ram_scan_reader;

   logic clk;
   logic reset1, enable1, reset2, enable2;
   logic [4:0] rd_addr1, disp_addr1, rd_addr2, disp_addr2;
   logic [2:0] rd_data1, disp_data1, rd_data2, disp_data2;
   logic disp_valid1, disp_valid2;

   logic       wr_en;
   logic [4:0] wr_addr;
   logic [2:0] wr_data;
   logic [2:0] mem [32];
   logic [2:0] p1, p2;

   int n_cmp = 0;
   int n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared storage; latency-1 read for dut1, three-stage read for dut2.
   always @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data1 <= mem[rd_addr1];
      p1       <= mem[rd_addr2];
      p2       <= p1;
      rd_data2 <= p2;
   end

   ram_scan_reader #(
      .ADDR_W(5), .DATA_W(3), .TICK_CYCLES(8), .RD_LATENCY(1)
   ) dut1 (
      .clk(clk), .reset(reset1), .enable(enable1),
      .rd_addr(rd_addr1), .rd_data(rd_data1),
      .disp_addr(disp_addr1), .disp_data(disp_data1), .disp_valid(disp_valid1)
   );

   ram_scan_reader #(
      .ADDR_W(5), .DATA_W(3), .TICK_CYCLES(8), .RD_LATENCY(3)
   ) dut2 (
      .clk(clk), .reset(reset2), .enable(enable2),
      .rd_addr(rd_addr2), .rd_data(rd_data2),
      .disp_addr(disp_addr2), .disp_data(disp_data2), .disp_valid(disp_valid2)
   );

   task automatic step_edge();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for a disp_valid pulse; returns edges consumed (max on timeout).
   task automatic wait_valid(input bit sel, input int max, output int n);
      n = 0;
      do begin
         step_edge();
         n++;
      end while (!((sel ? disp_valid2 : disp_valid1) === 1'b1) && n < max);
   endtask

   task automatic test_reset();
      int n;
      step_edge();
      step_edge();
      n_cmp++; if (rd_addr1 !== 5'd0) begin n_bad++; $display("FAIL rst_rd_addr got %0d want 0", rd_addr1); end
      n_cmp++; if (disp_addr1 !== 5'd0) begin n_bad++; $display("FAIL rst_disp_addr got %0d want 0", disp_addr1); end
      n_cmp++; if (disp_data1 !== 3'd0) begin n_bad++; $display("FAIL rst_disp_data got %0d want 0", disp_data1); end
      n_cmp++; if (disp_valid1 !== 1'b0) begin n_bad++; $display("FAIL rst_disp_valid got %0b want 0", disp_valid1); end
      reset1  = 1'b0;
      enable1 = 1'b1;
      wait_valid(1'b0, 40, n);
      n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL first_cap_gap got %0d want 2", n); end
      n_cmp++; if (disp_addr1 !== 5'd0) begin n_bad++; $display("FAIL first_cap_addr got %0d want 0", disp_addr1); end
      n_cmp++; if (disp_data1 !== 3'd0) begin n_bad++; $display("FAIL first_cap_data got %0d want 0", disp_data1); end
   endtask

   task automatic test_first_step();
      int n;
      wait_valid(1'b0, 40, n);
      n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL step1_gap got %0d want 8", n); end
      n_cmp++; if (disp_addr1 !== 5'd1) begin n_bad++; $display("FAIL step1_addr got %0d want 1", disp_addr1); end
      n_cmp++; if (disp_data1 !== 3'd1) begin n_bad++; $display("FAIL step1_data got %0d want 1", disp_data1); end
   endtask

   task automatic test_scan_wrap();
      int n;
      logic [4:0] ea;
      for (int k = 2; k <= 32; k++) begin
         ea = 5'(k % 32);
         wait_valid(1'b0, 40, n);
         n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL scan_gap k=%0d got %0d want 8", k, n); end
         n_cmp++; if (disp_addr1 !== ea) begin n_bad++; $display("FAIL scan_addr got %0d want %0d", disp_addr1, ea); end
         n_cmp++; if (disp_data1 !== 3'(k % 8)) begin n_bad++; $display("FAIL scan_data addr=%0d got %0d want %0d", ea, disp_data1, k % 8); end
      end
   endtask

   task automatic test_enable_hold();
      int n;
      int pulses;
      step_edge();
      n_cmp++; if (disp_valid1 !== 1'b0) begin n_bad++; $display("FAIL valid_one_cycle got %0b want 0", disp_valid1); end
      step_edge();
      step_edge();
      enable1 = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step_edge();
         if (disp_valid1 !== 1'b0) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL hold_pulses got %0d want 0", pulses); end
      n_cmp++; if (rd_addr1 !== 5'd0) begin n_bad++; $display("FAIL hold_rd_addr got %0d want 0", rd_addr1); end
      n_cmp++; if (disp_addr1 !== 5'd0) begin n_bad++; $display("FAIL hold_disp_addr got %0d want 0", disp_addr1); end
      enable1 = 1'b1;
      step_edge();
      step_edge();
      n_cmp++; if (rd_addr1 !== 5'd0) begin n_bad++; $display("FAIL reen_early_step got %0d want 0", rd_addr1); end
      step_edge();
      n_cmp++; if (rd_addr1 !== 5'd1) begin n_bad++; $display("FAIL reen_step got %0d want 1", rd_addr1); end
      n_cmp++; if (disp_addr1 !== 5'd0) begin n_bad++; $display("FAIL reen_disp_early got %0d want 0", disp_addr1); end
      wait_valid(1'b0, 40, n);
      n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL reen_cap_gap got %0d want 2", n); end
      n_cmp++; if (disp_addr1 !== 5'd1) begin n_bad++; $display("FAIL reen_cap_addr got %0d want 1", disp_addr1); end
      n_cmp++; if (disp_data1 !== 3'd1) begin n_bad++; $display("FAIL reen_cap_data got %0d want 1", disp_data1); end
   endtask

   task automatic test_show_write();
      int n;
      for (int k = 2; k <= 4; k++) begin
         wait_valid(1'b0, 40, n);
         n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL pre_wr_gap got %0d want 8", n); end
      end
      n_cmp++; if (disp_addr1 !== 5'd4) begin n_bad++; $display("FAIL pre_wr_addr got %0d want 4", disp_addr1); end
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 3'd6;
      step_edge();
      wr_en = 1'b0;
      n_cmp++; if (disp_data1 !== 3'd4) begin n_bad++; $display("FAIL wr_e1_data got %0d want 4", disp_data1); end
      step_edge();
      n_cmp++; if (disp_data1 !== 3'd4) begin n_bad++; $display("FAIL wr_e2_data got %0d want 4", disp_data1); end
      step_edge();
      n_cmp++; if (disp_data1 !== 3'd6) begin n_bad++; $display("FAIL wr_new_data got %0d want 6", disp_data1); end
      n_cmp++; if (disp_addr1 !== 5'd4) begin n_bad++; $display("FAIL wr_addr_stable got %0d want 4", disp_addr1); end
      n_cmp++; if (disp_valid1 !== 1'b0) begin n_bad++; $display("FAIL wr_no_valid got %0b want 0", disp_valid1); end
      wait_valid(1'b0, 40, n);
      n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL post_wr_gap got %0d want 5", n); end
      n_cmp++; if (disp_addr1 !== 5'd5 || disp_data1 !== 3'd5) begin n_bad++; $display("FAIL post_wr_pair got %0d/%0d want 5/5", disp_addr1, disp_data1); end
   endtask

   task automatic test_reset_mid();
      int n;
      for (int k = 6; k <= 8; k++) begin
         wait_valid(1'b0, 40, n);
         n_cmp++; if (n !== 8 || disp_addr1 !== 5'(k)) begin n_bad++; $display("FAIL pre_rst gap/addr got %0d/%0d want 8/%0d", n, disp_addr1, k); end
      end
      for (int i = 0; i < 5; i++) step_edge();
      n_cmp++; if (rd_addr1 !== 5'd8) begin n_bad++; $display("FAIL pre_step_addr got %0d want 8", rd_addr1); end
      step_edge();
      n_cmp++; if (rd_addr1 !== 5'd9) begin n_bad++; $display("FAIL settle9_rd_addr got %0d want 9", rd_addr1); end
      n_cmp++; if (disp_addr1 !== 5'd8) begin n_bad++; $display("FAIL settle9_disp_addr got %0d want 8", disp_addr1); end
      #2;
      reset1 = 1'b1;
      #1;
      n_cmp++; if (rd_addr1 !== 5'd0) begin n_bad++; $display("FAIL async_rd_addr got %0d want 0", rd_addr1); end
      n_cmp++; if (disp_addr1 !== 5'd0) begin n_bad++; $display("FAIL async_disp_addr got %0d want 0", disp_addr1); end
      n_cmp++; if (disp_data1 !== 3'd0) begin n_bad++; $display("FAIL async_disp_data got %0d want 0", disp_data1); end
      n_cmp++; if (disp_valid1 !== 1'b0) begin n_bad++; $display("FAIL async_disp_valid got %0b want 0", disp_valid1); end
      step_edge();
      step_edge();
      reset1 = 1'b0;
      wait_valid(1'b0, 40, n);
      n_cmp++; if (n !== 2 || disp_addr1 !== 5'd0 || disp_data1 !== 3'd0) begin n_bad++; $display("FAIL restart_cap got gap %0d addr %0d data %0d want 2/0/0", n, disp_addr1, disp_data1); end
      wait_valid(1'b0, 40, n);
      n_cmp++; if (n !== 8 || disp_addr1 !== 5'd1 || disp_data1 !== 3'd1) begin n_bad++; $display("FAIL restart_step got gap %0d addr %0d data %0d want 8/1/1", n, disp_addr1, disp_data1); end
   endtask

   task automatic test_latency3();
      int n;
      enable2 = 1'b1;
      step_edge();
      reset2 = 1'b0;
      wait_valid(1'b1, 40, n);
      n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL l3_first_gap got %0d want 4", n); end
      n_cmp++; if (disp_addr2 !== 5'd0 || disp_data2 !== 3'd0) begin n_bad++; $display("FAIL l3_first_pair got %0d/%0d want 0/0", disp_addr2, disp_data2); end
      for (int i = 0; i < 4; i++) step_edge();
      n_cmp++; if (rd_addr2 !== 5'd1) begin n_bad++; $display("FAIL l3_step_rd_addr got %0d want 1", rd_addr2); end
      n_cmp++; if (disp_addr2 !== 5'd0) begin n_bad++; $display("FAIL l3_step_disp_addr got %0d want 0", disp_addr2); end
      wait_valid(1'b1, 40, n);
      n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL l3_cap_gap got %0d want 4", n); end
      n_cmp++; if (disp_addr2 !== 5'd1 || disp_data2 !== 3'd1) begin n_bad++; $display("FAIL l3_cap_pair got %0d/%0d want 1/1", disp_addr2, disp_data2); end
      wait_valid(1'b1, 40, n);
      n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL l3_period got %0d want 8", n); end
      n_cmp++; if (disp_addr2 !== 5'd2 || disp_data2 !== 3'd2) begin n_bad++; $display("FAIL l3_pair2 got %0d/%0d want 2/2", disp_addr2, disp_data2); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 3'(i % 8);
      reset1 = 1'b1; enable1 = 1'b0;
      reset2 = 1'b1; enable2 = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      test_reset();
      test_first_step();
      test_scan_wrap();
      test_enable_hold();
      test_show_write();
      test_reset_mid();
      test_latency3();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
